// File: rtl/pitch_pkg.sv
// Shared definitions for the pitch-detection frame path.
// Holds the scheduler state encoding, frame buffer geometry, the default
// statistics counter width and a bank-select helper.
package pitch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_e;

    localparam int N_BANKS       = 2;
    localparam int FRAME_LEN     = 2048;
    localparam int ADDR_W        = 11;
    localparam int SAMPLE_W      = 12;
    localparam int CNT_W_DEFAULT = 16;

    // One-hot write enable for a bank index.
    function automatic logic [N_BANKS-1:0] bank_onehot(input logic bank);
        return N_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// Handshake bundle between the scheduler, the buffer writer and the f0
// estimator.
//   master: drives enable / frame_done / f0_done, observes scheduler outputs
//   slave : the scheduler itself
interface frame_bank_scheduler_if
    import pitch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic               enable;
    logic               frame_done;
    logic               f0_done;
    logic               start_round;
    logic [N_BANKS-1:0] wr_en;
    logic               f0_start;
    logic               rd_bank;
    logic               f0_busy;
    logic               stalled;
    logic [CNT_W-1:0]   frame_count;
    logic [CNT_W-1:0]   overrun_count;

    modport master (
        output enable, frame_done, f0_done,
        input  start_round, wr_en, f0_start, rd_bank, f0_busy, stalled,
               frame_count, overrun_count
    );

    modport slave (
        input  enable, frame_done, f0_done,
        output start_round, wr_en, f0_start, rd_bank, f0_busy, stalled,
               frame_count, overrun_count
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for the scheduler statistics.
//   clk, rst (sync, active-high), inc : count by one when set
//   count : current value, holds at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/frame_bank_scheduler.sv
// Ping-pong frame bank scheduler between the sample buffer writer and the
// f0 estimator. All outputs are registered.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of frame_bank_scheduler_if (enable, frame_done,
//              f0_done in; start_round, wr_en, f0_start, rd_bank, f0_busy,
//              stalled, frame_count, overrun_count out)
//
// state | meaning
// IDLE  | pipeline disabled, no bank written
// FILL  | writer filling wr_bank
// HOLD  | frame complete but estimator busy; writer held off
module frame_bank_scheduler
    import pitch_pkg::*;
#(
    parameter bit DROP_ON_OVERRUN = 1'b1,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    frame_bank_scheduler_if.slave bus
);
    if (FRAME_LEN != (1 << ADDR_W) || SAMPLE_W < 1) begin : g_cfg_bad
        $error("frame_bank_scheduler: inconsistent frame buffer geometry");
    end

    sched_state_e       state_q, state_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [N_BANKS-1:0] wr_en_q, wr_en_d;
    logic               f0_busy_q, f0_busy_d;
    logic               stalled_q, stalled_d;
    logic               start_round_q, start_round_d;
    logic               f0_start_q, f0_start_d;
    logic               frame_inc, ovr_inc;
    logic               do_swap;
    logic               frame_ok;
    logic               est_free;

    // A frame cannot complete in the cycle its start pulse is still out;
    // this also keeps start_round from firing on back-to-back cycles.
    assign frame_ok = bus.frame_done && !start_round_q;
    // Simultaneous f0_done and frame_done counts as a free estimator.
    assign est_free = !f0_busy_q || bus.f0_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_en_q       <= '0;
            f0_busy_q     <= 1'b0;
            stalled_q     <= 1'b0;
            start_round_q <= 1'b0;
            f0_start_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_en_q       <= wr_en_d;
            f0_busy_q     <= f0_busy_d;
            stalled_q     <= stalled_d;
            start_round_q <= start_round_d;
            f0_start_q    <= f0_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_en_d       = wr_en_q;
        f0_busy_d     = f0_busy_q;
        stalled_d     = stalled_q;
        start_round_d = 1'b0;
        f0_start_d    = 1'b0;
        frame_inc     = 1'b0;
        ovr_inc       = 1'b0;
        do_swap       = 1'b0;

        if (bus.f0_done) begin
            f0_busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                wr_en_d   = '0;
                stalled_d = 1'b0;
                if (bus.enable) begin
                    start_round_d = 1'b1;
                    wr_en_d       = bank_onehot(wr_bank_q);
                    state_d       = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!bus.enable) begin
                    wr_en_d   = '0;
                    stalled_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    wr_en_d = bank_onehot(wr_bank_q);
                    if (frame_ok) begin
                        if (est_free) begin
                            do_swap = 1'b1;
                        end else if (DROP_ON_OVERRUN) begin
                            start_round_d = 1'b1;
                            ovr_inc       = 1'b1;
                        end else begin
                            wr_en_d   = '0;
                            stalled_d = 1'b1;
                            ovr_inc   = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.enable) begin
                    wr_en_d   = '0;
                    stalled_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (bus.f0_done) begin
                    do_swap   = 1'b1;
                    stalled_d = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            default: begin
                wr_en_d   = '0;
                stalled_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Hand the just-filled bank to the estimator and restart the writer
        // on the other one.
        if (do_swap) begin
            rd_bank_d     = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
            wr_en_d       = bank_onehot(~wr_bank_q);
            start_round_d = 1'b1;
            f0_start_d    = 1'b1;
            f0_busy_d     = 1'b1;
            frame_inc     = 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_inc),
        .count (bus.frame_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_ovr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ovr_inc),
        .count (bus.overrun_count)
    );

    assign bus.start_round = start_round_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.f0_start    = f0_start_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.f0_busy     = f0_busy_q;
    assign bus.stalled     = stalled_q;
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench: one drop-policy scheduler (narrow counters, to reach
// saturation) and one stall-policy scheduler, driven with identical inputs.
module tb_frame_bank_scheduler;
    import pitch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic fd  = 1'b0;
    logic fdn = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    frame_bank_scheduler_if #(.CNT_W(3))  if_d ();
    frame_bank_scheduler_if #(.CNT_W(16)) if_s ();

    assign if_d.enable     = en;
    assign if_d.frame_done = fd;
    assign if_d.f0_done    = fdn;
    assign if_s.enable     = en;
    assign if_s.frame_done = fd;
    assign if_s.f0_done    = fdn;

    frame_bank_scheduler #(.DROP_ON_OVERRUN(1'b1), .CNT_W(3)) dut_drop (
        .clk (clk),
        .rst (rst),
        .bus (if_d)
    );

    frame_bank_scheduler #(.DROP_ON_OVERRUN(1'b0), .CNT_W(16)) dut_stall (
        .clk (clk),
        .rst (rst),
        .bus (if_s)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse(input logic f, input logic d);
        fd  = f;
        fdn = d;
        step(1);
        fd  = 1'b0;
        fdn = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk_eq({tag, " drop sr"},   32'(if_d.start_round), 0);
        chk_eq({tag, " drop wren"}, 32'(if_d.wr_en), 0);
        chk_eq({tag, " drop f0s"},  32'(if_d.f0_start), 0);
        chk_eq({tag, " drop rdb"},  32'(if_d.rd_bank), 0);
        chk_eq({tag, " drop busy"}, 32'(if_d.f0_busy), 0);
        chk_eq({tag, " drop fc"},   32'(if_d.frame_count), 0);
        chk_eq({tag, " drop oc"},   32'(if_d.overrun_count), 0);
        chk_eq({tag, " stall sr"},  32'(if_s.start_round), 0);
        chk_eq({tag, " stall wren"},32'(if_s.wr_en), 0);
        chk_eq({tag, " stall busy"},32'(if_s.f0_busy), 0);
        chk_eq({tag, " stall stl"}, 32'(if_s.stalled), 0);
        chk_eq({tag, " stall fc"},  32'(if_s.frame_count), 0);
        chk_eq({tag, " stall oc"},  32'(if_s.overrun_count), 0);
    endtask

    initial begin
        // Reset, then enable
        step(2);
        rst = 1'b0;
        step(1);
        chk_reset("rst");
        en = 1'b1;
        step(1);
        chk_eq("en sr",   32'(if_d.start_round), 1);
        chk_eq("en wren", 32'(if_d.wr_en), 32'h1);
        chk_eq("en stall wren", 32'(if_s.wr_en), 32'h1);
        step(1);
        chk_eq("en sr single", 32'(if_d.start_round), 0);
        chk_eq("en wren hold", 32'(if_d.wr_en), 32'h1);

        // Normal ping-pong
        step(5);
        pulse(1'b1, 1'b0);
        chk_eq("pp1 f0s",  32'(if_d.f0_start), 1);
        chk_eq("pp1 sr",   32'(if_d.start_round), 1);
        chk_eq("pp1 rdb",  32'(if_d.rd_bank), 0);
        chk_eq("pp1 wren", 32'(if_d.wr_en), 32'h2);
        chk_eq("pp1 busy", 32'(if_d.f0_busy), 1);
        chk_eq("pp1 fc",   32'(if_d.frame_count), 1);
        chk_eq("pp1 stall wren", 32'(if_s.wr_en), 32'h2);
        step(1);
        chk_eq("pp1 f0s single", 32'(if_d.f0_start), 0);
        step(47);
        pulse(1'b0, 1'b1);
        chk_eq("f0done busy", 32'(if_d.f0_busy), 0);
        step(49);
        pulse(1'b1, 1'b0);
        chk_eq("pp2 rdb",  32'(if_d.rd_bank), 1);
        chk_eq("pp2 wren", 32'(if_d.wr_en), 32'h1);
        chk_eq("pp2 fc",   32'(if_d.frame_count), 2);
        chk_eq("pp2 f0s",  32'(if_d.f0_start), 1);
        chk_eq("pp2 stall fc", 32'(if_s.frame_count), 2);

        // Overrun while the estimator is busy on bank1, writer on bank0
        step(10);
        pulse(1'b1, 1'b0);
        chk_eq("ovr drop sr",   32'(if_d.start_round), 1);
        chk_eq("ovr drop wren", 32'(if_d.wr_en), 32'h1);
        chk_eq("ovr drop oc",   32'(if_d.overrun_count), 1);
        chk_eq("ovr drop f0s",  32'(if_d.f0_start), 0);
        chk_eq("ovr drop fc",   32'(if_d.frame_count), 2);
        chk_eq("ovr stall wren",32'(if_s.wr_en), 0);
        chk_eq("ovr stall stl", 32'(if_s.stalled), 1);
        chk_eq("ovr stall oc",  32'(if_s.overrun_count), 1);
        chk_eq("ovr stall sr",  32'(if_s.start_round), 0);
        step(19);
        pulse(1'b0, 1'b1);
        chk_eq("hold f0s",  32'(if_s.f0_start), 1);
        chk_eq("hold sr",   32'(if_s.start_round), 1);
        chk_eq("hold stl",  32'(if_s.stalled), 0);
        chk_eq("hold rdb",  32'(if_s.rd_bank), 0);
        chk_eq("hold wren", 32'(if_s.wr_en), 32'h2);
        chk_eq("hold fc",   32'(if_s.frame_count), 3);
        chk_eq("hold drop sr",   32'(if_d.start_round), 0);
        chk_eq("hold drop busy", 32'(if_d.f0_busy), 0);

        // Simultaneous frame_done and f0_done while busy
        en  = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        en  = 1'b1;
        step(2);
        pulse(1'b1, 1'b0);
        step(5);
        pulse(1'b1, 1'b1);
        chk_eq("sim rdb",  32'(if_d.rd_bank), 1);
        chk_eq("sim wren", 32'(if_d.wr_en), 32'h1);
        chk_eq("sim f0s",  32'(if_d.f0_start), 1);
        chk_eq("sim busy", 32'(if_d.f0_busy), 1);
        chk_eq("sim fc",   32'(if_d.frame_count), 2);
        chk_eq("sim oc",   32'(if_d.overrun_count), 0);
        chk_eq("sim stall oc",  32'(if_s.overrun_count), 0);
        chk_eq("sim stall stl", 32'(if_s.stalled), 0);

        // Abort mid-frame with the estimator busy on bank1
        step(3);
        en = 1'b0;
        step(1);
        chk_eq("abort wren", 32'(if_d.wr_en), 0);
        chk_eq("abort busy", 32'(if_d.f0_busy), 1);
        chk_eq("abort stall wren", 32'(if_s.wr_en), 0);
        step(3);
        en = 1'b1;
        step(1);
        chk_eq("reen sr",   32'(if_d.start_round), 1);
        chk_eq("reen wren", 32'(if_d.wr_en), 32'h1);
        chk_eq("reen rdb",  32'(if_d.rd_bank), 1);
        chk_eq("reen stall wren", 32'(if_s.wr_en), 32'h1);

        // Overrun counter saturation on the 3-bit drop counter
        step(1);
        for (int i = 0; i < 10; i++) begin
            pulse(1'b1, 1'b0);
            step(1);
        end
        chk_eq("sat drop oc",  32'(if_d.overrun_count), 7);
        chk_eq("sat drop fc",  32'(if_d.frame_count), 2);
        chk_eq("sat stall oc", 32'(if_s.overrun_count), 1);
        chk_eq("sat stall stl",32'(if_s.stalled), 1);

        // Reset mid-operation
        rst = 1'b1;
        step(1);
        chk_reset("midrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
